rr_decoder_arbiter: RTL and testbench

RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

---
 rtl/rr_decoder_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter
// Round-robin arbiter for 8 requesters. A grant is presented as a
// binary index (o_sel) and an active-low one-hot vector (o_y). Each
// grant lasts at most HOLD_CYCLES cycles, followed by GAP_CYCLES idle
// cycles. After a grant, the requester just granted has the lowest
// priority in the next arbitration.
//
// Ports:
//   i_clk      - clock; all state updates on its rising edge
//   i_rst      - asynchronous active-high reset
//   i_req      - request vector; bit k = requester k wants the resource
//   i_release  - current grantee ends its grant early
//   o_sel      - index of the current or most recent grantee (registered)
//   o_y        - active-low one-hot grant, all ones when not granting (registered)
//   o_valid    - high while in GRANT (registered)
//   o_busy     - high while in GRANT or GAP (registered)
module rr_decoder_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_release,
    output logic [2:0] o_sel,
    output logic [7:0] o_y,
    output logic       o_valid,
    output logic       o_busy
);

    localparam int unsigned N      = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned GAP_W  = 4;

    // Terminal counts; GAP_LAST is never used when the gap is disabled.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic              GAP_EN    = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [IDX_W-1:0]    sel_d;
    logic [N-1:0]        y_d;
    logic                valid_d;
    logic                busy_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                grant_end;

    // Round-robin search starting just after the last grantee; the final
    // candidate (offset 8) wraps back to the last grantee itself.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= int'(N); i++) begin
            if (!pick_found && i_req[last_q + IDX_W'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = last_q + IDX_W'(i);
            end
        end
    end

    // Any of terminal count, early release or a dropped request ends the grant.
    assign grant_end = (hold_q == HOLD_LAST) || i_release || !i_req[o_sel];

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        sel_d   = o_sel;
        y_d     = o_y;
        valid_d = o_valid;
        busy_d  = o_busy;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    last_d  = pick_idx;
                    hold_d  = '0;
                    sel_d   = pick_idx;
                    y_d     = ~(N'(1) << pick_idx);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            GRANT: begin
                if (grant_end) begin
                    hold_d  = '0;
                    y_d     = '1;
                    valid_d = 1'b0;
                    if (GAP_EN) begin
                        state_d = GAP;
                        gap_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                y_d     = '1;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs. Reset seeds last_q with 7 so
    // the first arbitration starts at index 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            hold_q  <= '0;
            gap_q   <= '0;
            o_sel   <= 3'd0;
            o_y     <= 8'hFF;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            o_sel   <= sel_d;
            o_y     <= y_d;
            o_valid <= valid_d;
            o_busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: directed stimulus pushes expected grants
// (index, one-hot value, length, idle gap before it) into a queue; a
// monitor closes each observed grant and compares it against the queue.
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [2:0] sel;
    logic [7:0] y;
    logic       valid;
    logic       busy;

    logic [7:0] req2;
    logic [2:0] sel2;
    logic [7:0] y2;
    logic       valid2;
    logic       busy2;

    rr_decoder_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_release (rel),
        .o_sel     (sel),
        .o_y       (y),
        .o_valid   (valid),
        .o_busy    (busy)
    );

    rr_decoder_arbiter #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req2),
        .i_release (1'b0),
        .o_sel     (sel2),
        .o_y       (y2),
        .o_valid   (valid2),
        .o_busy    (busy2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [7:0] y;
        int         len;
        int         gap;   // -1: first grant after reset, gap not checked
    } grant_t;

    grant_t exp_q[$];

    task automatic expect_grant(input logic [2:0] s, input logic [7:0] yv, input int len, input int gap);
        grant_t g;
        g.sel = s;
        g.y   = yv;
        g.len = len;
        g.gap = gap;
        exp_q.push_back(g);
    endtask

    // Monitor state
    logic       in_grant    = 1'b0;
    logic       after_reset = 1'b1;
    int         idle_cnt    = 0;
    logic [2:0] cur_sel;
    logic [7:0] cur_y;
    int         cur_len;
    int         cur_gap;

    task automatic close_grant();
        grant_t g;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got sel=%0d y=%0h len=%0d expected none", cur_sel, cur_y, cur_len);
        end else begin
            g = exp_q.pop_front();
            chk("grant_sel", 32'(cur_sel), 32'(g.sel));
            chk("grant_y", 32'(cur_y), 32'(g.y));
            chk("grant_len", 32'(cur_len), 32'(g.len));
            if (g.gap >= 0)
                chk("grant_gap", 32'(cur_gap), 32'(g.gap));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (in_grant)
                close_grant();
            in_grant    = 1'b0;
            after_reset = 1'b1;
            idle_cnt    = 0;
        end else if (valid) begin
            if (!in_grant) begin
                in_grant = 1'b1;
                cur_sel  = sel;
                cur_y    = y;
                cur_len  = 0;
                cur_gap  = after_reset ? -1 : idle_cnt;
            end
            cur_len++;
        end else begin
            if (in_grant) begin
                close_grant();
                in_grant    = 1'b0;
                after_reset = 1'b0;
                idle_cnt    = 0;
            end
            idle_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    logic [7:0] y_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic       v2_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] s2_tab [6] = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0};
    logic [7:0] y2_tab [6] = '{8'hFE, 8'hFF, 8'h7F, 8'hFF, 8'hFE, 8'hFF};

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        rel  = 1'b0;
        req2 = 8'h00;
        tick(2);
        @(negedge clk);
        chk("rst_y", 32'(y), 32'h FF);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_y2", 32'(y2), 32'hFF);
        tick(1);
        rst = 1'b0;

        // Single requester held: grant 4, gap, idle, regrant
        expect_grant(3'd0, 8'hFE, 4, -1);
        expect_grant(3'd0, 8'hFE, 4, 2);
        req = 8'h01;
        tick(10);
        req = 8'h00;
        tick(4);
        @(negedge clk);
        chk("idle_y", 32'(y), 32'hFF);
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sel_hold", 32'(sel), 32'd0);

        // All requesting: full rotation 0..7 then 0 again
        do_reset();
        for (int k = 0; k < 8; k++)
            expect_grant(3'(k), y_tab[k], 4, (k == 0) ? -1 : 2);
        expect_grant(3'd0, 8'hFE, 4, 2);
        req = 8'hFF;
        tick(52);
        req = 8'h00;
        tick(4);

        // Early release in hold cycle 1 of grant 3
        do_reset();
        expect_grant(3'd3, 8'hF7, 2, -1);
        req = 8'h08;
        tick(2);
        rel = 1'b1;
        tick(1);
        rel = 1'b0;
        req = 8'h00;
        @(negedge clk);
        chk("rel_y", 32'(y), 32'hFF);
        chk("rel_valid", 32'(valid), 32'd0);
        chk("rel_gap_busy", 32'(busy), 32'd1);
        chk("rel_gap_sel", 32'(sel), 32'd3);
        tick(1);
        @(negedge clk);
        chk("rel_idle_busy", 32'(busy), 32'd0);
        chk("rel_idle_sel", 32'(sel), 32'd3);
        tick(2);

        // Grantee 5 drops its request, requester 6 follows
        do_reset();
        expect_grant(3'd5, 8'hDF, 2, -1);
        expect_grant(3'd6, 8'hBF, 4, 2);
        req = 8'h60;
        tick(2);
        req = 8'h40;
        tick(6);
        req = 8'h00;
        tick(4);

        // Asynchronous reset mid-grant, then 0x88 picks index 3 first
        do_reset();
        expect_grant(3'd0, 8'hFE, 1, -1);
        expect_grant(3'd3, 8'hF7, 4, -1);
        req = 8'h01;
        tick(2);
        rst = 1'b1;
        #1;
        chk("async_rst_y", 32'(y), 32'hFF);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_sel", 32'(sel), 32'd0);
        tick(1);
        rst = 1'b0;
        req = 8'h88;
        tick(4);
        req = 8'h00;
        tick(4);

        // No gap, hold 1: alternating 0 and 7 with one idle cycle between
        do_reset();
        req2 = 8'h81;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            @(negedge clk);
            chk("nogap_valid", 32'(valid2), 32'(v2_tab[i]));
            chk("nogap_busy", 32'(busy2), 32'(v2_tab[i]));
            chk("nogap_sel", 32'(sel2), 32'(s2_tab[i]));
            chk("nogap_y", 32'(y2), 32'(y2_tab[i]));
        end
        req2 = 8'h00;
        tick(3);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
